pwm_duty_ramp: RTL

//  Duty-cycle sequencer for the 8-bit pwm generator driving each follower motor.

---
 rtl/pwm_duty_ramp_pkg.sv | 19 +
 rtl/pwm_duty_ramp_duty_step.sv | 45 ++++
 rtl/pwm_duty_ramp.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pwm_duty_ramp_pkg.sv
// ---------------------------------------------------------------------------
// follower_pkg
//   Shared types and constants for the follower-motor PWM duty path.
//   ramp_state_t : duty sequencer states (IDLE, RAMP, BRAKE)
//   PWM_W        : width of the pwm counter and duty word
//   PWM_MAX      : last pwm count of a period (period boundary marker)
// ---------------------------------------------------------------------------
package follower_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    BRAKE = 2'd2
  } ramp_state_t;

  localparam int              PWM_W   = 8;
  localparam logic [PWM_W-1:0] PWM_MAX = 8'hFF;

endpackage

// File: rtl/pwm_duty_ramp_duty_step.sv
// ---------------------------------------------------------------------------
// duty_step
//   Combinational saturating step of the applied duty toward the target.
//   Moves by at most STEP; lands exactly on the target when closer than that,
//   so the result never overshoots and never wraps past 0 or 255.
// Ports
//   duty      in   8  currently applied duty
//   target    in   8  duty being ramped toward
//   next_duty out  8  duty after one ramp update
//   at_target out  1  next_duty equals target
// ---------------------------------------------------------------------------
module duty_step
  import follower_pkg::*;
#(
  parameter int STEP = 4
) (
  input  logic [7:0] duty,
  input  logic [7:0] target,
  output logic [7:0] next_duty,
  output logic       at_target
);

  localparam logic [PWM_W-1:0] STEP_8 = PWM_W'(STEP);
  localparam logic [PWM_W:0]   STEP_9 = {1'b0, STEP_8};

  // 9-bit differences so the magnitude compare against STEP cannot wrap.
  logic [PWM_W:0] diff_up;
  logic [PWM_W:0] diff_dn;

  always_comb begin
    diff_up   = {1'b0, target} - {1'b0, duty};
    diff_dn   = {1'b0, duty} - {1'b0, target};
    next_duty = duty;
    if (target > duty) begin
      // duty + STEP stays below target here, so the 8-bit add cannot carry out
      next_duty = (diff_up > STEP_9) ? (duty + STEP_8) : target;
    end else if (target < duty) begin
      // duty - STEP stays above target here, so the 8-bit subtract cannot borrow
      next_duty = (diff_dn > STEP_9) ? (duty - STEP_8) : target;
    end
  end

  assign at_target = (next_duty == target);

endmodule

// File: rtl/pwm_duty_ramp.sv
// ---------------------------------------------------------------------------
// pwm_duty_ramp
//   Duty-cycle sequencer for one follower motor's 8-bit pwm generator.
//   Accepts target-duty requests over valid/ready, slews the applied duty
//   toward the target by at most STEP per ramp update, and only ever changes
//   duty on the last count of a pwm period so pwm never sees a mid-period
//   change. Brake overrides everything and drives duty to 0.
// Parameters
//   STEP      max |duty change| per ramp update (1..255)
//   RAMP_DIV  pwm periods per ramp update (1..16)
// Ports
//   clk       in   1  system clock, shared with the pwm instance
//   rst_n     in   1  asynchronous active-low reset
//   req_vld   in   1  new target duty offered
//   req_duty  in   8  requested target duty
//   req_rdy   out  1  request taken when req_vld & req_rdy at posedge clk
//   brake     in   1  level; force duty to 0 and hold
//   duty      out  8  registered duty to pwm.duty
//   busy      out  1  not idle, or a request is pending
//   done      out  1  one-cycle pulse when duty reaches target
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | duty == target, nothing in flight
// RAMP  | stepping duty toward target on each ramp tick
// BRAKE | brake seen; duty forced to 0 at the next period boundary
// ---------------------------------------------------------------------------
module pwm_duty_ramp
  import follower_pkg::*;
#(
  parameter int STEP     = 4,
  parameter int RAMP_DIV = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_vld,
  input  logic [7:0] req_duty,
  output logic       req_rdy,
  input  logic       brake,
  output logic [7:0] duty,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] DIV_LAST = 4'(RAMP_DIV - 1);

  ramp_state_t      state;
  ramp_state_t      state_nxt;
  logic [PWM_W-1:0] prd_cnt;
  logic [3:0]       div_cnt;
  logic [3:0]       div_nxt;
  logic [PWM_W-1:0] target;
  logic [PWM_W-1:0] target_nxt;
  logic             pend_vld;
  logic             pend_vld_nxt;
  logic [PWM_W-1:0] pend_duty;
  logic [PWM_W-1:0] pend_duty_nxt;
  logic [PWM_W-1:0] duty_nxt;
  logic             done_nxt;

  logic             bnd;
  logic             tick;
  logic             accept;
  logic             load;
  logic             step_hit;
  logic [PWM_W-1:0] step_duty;
  logic             step_at_target;

  // Free-running period counter, kept in lockstep with the pwm counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prd_cnt <= '0;
    end else begin
      prd_cnt <= prd_cnt + 8'd1;
    end
  end

  assign bnd     = (prd_cnt == PWM_MAX);
  assign tick    = bnd && (div_cnt == DIV_LAST);
  assign req_rdy = !pend_vld && !brake;
  assign accept  = req_vld && req_rdy;
  assign busy    = (state != IDLE) || pend_vld;

  // Steps always use the target held before this cycle, so a reload landing
  // on a tick only affects the following tick.
  duty_step #(
    .STEP (STEP)
  ) u_duty_step (
    .duty      (duty),
    .target    (target),
    .next_duty (step_duty),
    .at_target (step_at_target)
  );

  always_comb begin
    state_nxt     = state;
    duty_nxt      = duty;
    target_nxt    = target;
    pend_vld_nxt  = pend_vld;
    pend_duty_nxt = pend_duty;
    done_nxt      = 1'b0;
    div_nxt       = div_cnt;
    load          = 1'b0;
    step_hit      = 1'b0;

    if (bnd) begin
      div_nxt = (div_cnt == DIV_LAST) ? 4'd0 : (div_cnt + 4'd1);
    end

    if (brake) begin
      state_nxt    = BRAKE;
      target_nxt   = '0;
      pend_vld_nxt = 1'b0;
      div_nxt      = 4'd0;
      if (bnd) begin
        duty_nxt = '0;
      end
    end else begin
      // The pending entry is held through BRAKE and only loaded once the
      // sequencer is back in IDLE or RAMP.
      load = bnd && pend_vld && (state != BRAKE);
      if (load) begin
        target_nxt   = pend_duty;
        pend_vld_nxt = 1'b0;
      end
      if (accept) begin
        pend_vld_nxt  = 1'b1;
        pend_duty_nxt = req_duty;
      end

      // Completion is judged against the target that will be in force after
      // this edge, so a reload onto the stepped value also ends the ramp.
      step_hit = load ? (step_duty == pend_duty) : step_at_target;

      case (state)
        IDLE: begin
          if (load) begin
            if (pend_duty == duty) begin
              done_nxt = 1'b1;
            end else begin
              state_nxt = RAMP;
            end
          end
        end
        RAMP: begin
          if (tick) begin
            duty_nxt = step_duty;
            if (step_hit) begin
              done_nxt  = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
        BRAKE: begin
          // A brake released before any boundary still has to zero duty at
          // a boundary before handing back to IDLE.
          if (bnd || (duty == '0)) begin
            duty_nxt  = '0;
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      div_cnt   <= 4'd0;
      duty      <= '0;
      target    <= '0;
      pend_vld  <= 1'b0;
      pend_duty <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      div_cnt   <= div_nxt;
      duty      <= duty_nxt;
      target    <= target_nxt;
      pend_vld  <= pend_vld_nxt;
      pend_duty <= pend_duty_nxt;
      done      <= done_nxt;
    end
  end

endmodule
